// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice as a length-N multiply-accumulate engine and returns the 48-bit sum.
// Optional carry-out overflow flag (OVF) is compiled in with `define DSP_MAC_OVF_EN.
module dsp_mac_sequencer #(
  parameter int          LEN_W      = 16,
  parameter int          PIPE_LAT   = 2,
  parameter logic [7:0]  OPMODE_MAC = 8'h09
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic [47:0]      RESULT,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [17:0]      S_A,
  input  logic [17:0]      S_B,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CEA,
  output logic             DSP_CEB,
  output logic             DSP_CEM,
  output logic             DSP_CEP,
  output logic             DSP_CEOPMODE,
  output logic             DSP_RSTP,
`ifdef DSP_MAC_OVF_EN
  input  logic             DSP_CARRYOUT,
  output logic             OVF,
`endif
  input  logic [47:0]      DSP_P
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t             state_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   cnt_r;
  logic [LEN_W-1:0]   cnt_inc_s;
  logic [PIPE_LAT-1:0] vpipe_r;
  logic [PIPE_LAT-1:0] vnext_s;
  logic               accept_s;
  logic               last_s;
  logic               vout_s;
  logic               pipe_empty_next_s;
  logic               accum_phase_s;
  logic               s_ready_r;
  logic               busy_r;
  logic               done_r;
  logic               ce_am_r;
  logic               ceop_r;
  logic               rstp_r;
  logic [7:0]         opmode_r;
  logic [47:0]        result_r;

  assign accept_s          = S_VALID & s_ready_r;
  assign cnt_inc_s         = cnt_r + LEN_W'(1);
  assign last_s            = (cnt_inc_s == len_r);
  assign vout_s            = vpipe_r[PIPE_LAT-1];
  assign pipe_empty_next_s = (vnext_s == {PIPE_LAT{1'b0}});
  assign accum_phase_s     = (state_r == ST_FEED) || (state_r == ST_DRAIN);

  generate
    if (PIPE_LAT > 1) begin : g_deep_pipe
      assign vnext_s = {vpipe_r[PIPE_LAT-2:0], accept_s};
    end else begin : g_single_pipe
      assign vnext_s = accept_s;
    end
  endgenerate

  // Operands pass straight through on accept; the slice's A1/B1 registers form the first stage.
  assign DSP_A        = accept_s ? S_A : 18'd0;
  assign DSP_B        = accept_s ? S_B : 18'd0;
  assign DSP_CEP      = (state_r == ST_CLEAR) | (vout_s & accum_phase_s);
  assign DSP_CEA      = ce_am_r;
  assign DSP_CEB      = ce_am_r;
  assign DSP_CEM      = ce_am_r;
  assign DSP_CEOPMODE = ceop_r;
  assign DSP_RSTP     = rstp_r;
  assign DSP_OPMODE   = opmode_r;
  assign S_READY      = s_ready_r;
  assign BUSY         = busy_r;
  assign DONE         = done_r;
  assign RESULT       = result_r;

  // Command sequencer: state, operand counter, valid pipe and registered slice controls.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r   <= ST_IDLE;
      len_r     <= {LEN_W{1'b0}};
      cnt_r     <= {LEN_W{1'b0}};
      vpipe_r   <= {PIPE_LAT{1'b0}};
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ce_am_r   <= 1'b0;
      ceop_r    <= 1'b0;
      rstp_r    <= 1'b0;
      opmode_r  <= 8'h00;
      result_r  <= 48'd0;
    end else begin
      vpipe_r <= vnext_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // busy_r still high marks the DONE cycle, where a new START is refused.
          if (START && !busy_r) begin
            len_r    <= LEN;
            cnt_r    <= {LEN_W{1'b0}};
            busy_r   <= 1'b1;
            rstp_r   <= 1'b1;
            ceop_r   <= 1'b1;
            opmode_r <= OPMODE_MAC;
            state_r  <= ST_CLEAR;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          rstp_r  <= 1'b0;
          ceop_r  <= 1'b0;
          ce_am_r <= 1'b1;
          if (len_r != {LEN_W{1'b0}}) begin
            s_ready_r <= 1'b1;
            state_r   <= ST_FEED;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_FEED: begin
          if (accept_s) begin
            cnt_r <= cnt_inc_s;
            if (last_s) begin
              s_ready_r <= 1'b0;
              state_r   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Leave as the final product is being added, so FIN sees the finished P.
          if (pipe_empty_next_s) begin
            state_r <= ST_FIN;
          end
        end
        ST_FIN: begin
          result_r <= DSP_P;
          done_r   <= 1'b1;
          ce_am_r  <= 1'b0;
          opmode_r <= 8'h00;
          state_r  <= ST_IDLE;
        end
        default: begin
          s_ready_r <= 1'b0;
          busy_r    <= 1'b0;
          ce_am_r   <= 1'b0;
          ceop_r    <= 1'b0;
          rstp_r    <= 1'b0;
          opmode_r  <= 8'h00;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DSP_MAC_OVF_EN
  logic vout_d_r;
  logic ovf_sticky_r;
  logic ovf_r;
  logic carry_hit_s;

  // CARRYOUT is registered with P, so it lines up with the valid pipe delayed by one cycle.
  assign carry_hit_s = vout_d_r & DSP_CARRYOUT;
  assign OVF         = ovf_r;

  // Sticky overflow tracking, published alongside RESULT.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vout_d_r     <= 1'b0;
      ovf_sticky_r <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      vout_d_r <= vout_s;
      if (state_r == ST_CLEAR) begin
        ovf_sticky_r <= 1'b0;
      end else if (carry_hit_s) begin
        ovf_sticky_r <= 1'b1;
      end
      if (state_r == ST_FIN) begin
        ovf_r <= ovf_sticky_r | carry_hit_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a small DSP48A1 behavioural model
// (A1/B1, M, OPMODE and P registers) closing the loop through DSP_P.
module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        START = 1'b0;
  logic [15:0] LEN = 16'd0;
  logic        S_VALID = 1'b0;
  logic [17:0] S_A = 18'd0;
  logic [17:0] S_B = 18'd0;
  logic        BUSY, DONE, S_READY;
  logic [47:0] RESULT, DSP_P;
  logic [17:0] DSP_A, DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE, DSP_RSTP;
`ifdef DSP_MAC_OVF_EN
  logic        OVF;
`endif

  dsp_mac_sequencer dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE),
    .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP),
    .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_RSTP(DSP_RSTP),
`ifdef DSP_MAC_OVF_EN
    .DSP_CARRYOUT(1'b0), .OVF(OVF),
`endif
    .DSP_P(DSP_P)
  );

  always #5 CLK = ~CLK;

  // Slice model: A1/B1 -> M -> P accumulate, opmode X=M when 01, Z=P when 10.
  logic signed [17:0] a1_r = 18'sd0, b1_r = 18'sd0;
  logic signed [35:0] m_r = 36'sd0;
  logic [7:0]         opm_r = 8'h00;
  logic [47:0]        p_r = 48'd0;
  logic [47:0]        xmux, zmux;
  assign xmux  = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
  assign zmux  = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
  assign DSP_P = p_r;
  always @(posedge CLK) begin
    if (DSP_CEA) a1_r <= DSP_A;
    if (DSP_CEB) b1_r <= DSP_B;
    if (DSP_CEM) m_r <= a1_r * b1_r;
    if (DSP_CEOPMODE) opm_r <= DSP_OPMODE;
    if (DSP_RSTP) p_r <= 48'd0;
    else if (DSP_CEP) p_r <= xmux + zmux;
  end

  // Event counters sampled mid-cycle.
  int done_cnt = 0, cep_cnt = 0, rdy_cnt = 0;
  always @(negedge CLK) begin
    if (DONE) done_cnt <= done_cnt + 1;
    if (DSP_CEP && !DSP_RSTP) cep_cnt <= cep_cnt + 1;
    if (S_READY) rdy_cnt <= rdy_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          len;
    int          gap [4];
    logic [17:0] a [4];
    logic [17:0] b [4];
    logic [47:0] res;
    int          rdy;
  } vec_t;

  vec_t vecs [7];

  // Issues one command at a negedge, feeds its pairs with the given bubbles, checks the outcome.
  task automatic run_vec(input vec_t v, input bit hold, input string tag);
    int k, idx, gap_left, last_acc, done_k, d0, c0, r0;
    logic [47:0] res;
    d0 = done_cnt; c0 = cep_cnt; r0 = rdy_cnt;
    res = 48'd0;
    @(negedge CLK);
    check({tag, "_busy_before"}, {47'd0, BUSY}, 48'd0);
    START = 1'b1; LEN = v.len[15:0];
    k = 0; idx = 0; gap_left = v.gap[0]; last_acc = 0; done_k = -1;
    while (done_k < 0 && k < 300) begin
      @(negedge CLK);
      k++;
      if (!hold) START = 1'b0;
      if (k == 1) check({tag, "_busy_after_start"}, {47'd0, BUSY}, 48'd1);
      if (DONE) begin
        done_k = k;
        res = RESULT;
      end
      if (idx < v.len) begin
        if (gap_left > 0) begin
          S_VALID = 1'b0;
          gap_left--;
        end else begin
          S_VALID = 1'b1; S_A = v.a[idx]; S_B = v.b[idx];
          if (S_READY) begin
            last_acc = k;
            idx++;
            if (idx < v.len) gap_left = v.gap[idx];
          end
        end
      end else begin
        S_VALID = 1'b0;
      end
    end
    if (done_k < 0) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: actual no DONE required DONE within 300 cycles", tag);
    end else begin
      check({tag, "_result"}, res, v.res);
      check({tag, "_latency"}, 48'(done_k - last_acc), 48'd4);
      @(negedge CLK);
      check({tag, "_busy_after_done"}, {47'd0, BUSY}, 48'd0);
      #1;
      check({tag, "_done_pulses"}, 48'(done_cnt - d0), 48'd1);
      check({tag, "_cep_cycles"}, 48'(cep_cnt - c0), 48'(v.len));
      check({tag, "_ready_cycles"}, 48'(rdy_cnt - r0), 48'(v.rdy));
    end
  endtask

  initial begin
    vec_t hv, rv;
    int d0, n;
    vecs[0] = '{len: 4, gap: '{0, 0, 0, 0}, a: '{18'd1, 18'd3, 18'd5, 18'd7},
                b: '{18'd2, 18'd4, 18'd6, 18'd8}, res: 48'd100, rdy: 4};
    vecs[1] = '{len: 3, gap: '{0, 2, 1, 0}, a: '{18'd10, 18'd2, 18'd4, 18'd0},
                b: '{18'd10, 18'd3, 18'd5, 18'd0}, res: 48'd126, rdy: 6};
    vecs[2] = '{len: 0, gap: '{0, 0, 0, 0}, a: '{18'd0, 18'd0, 18'd0, 18'd0},
                b: '{18'd0, 18'd0, 18'd0, 18'd0}, res: 48'd0, rdy: 0};
    vecs[3] = '{len: 2, gap: '{0, 0, 0, 0}, a: '{18'd1, 18'd1, 18'd0, 18'd0},
                b: '{18'd1, 18'd1, 18'd0, 18'd0}, res: 48'd2, rdy: 2};
    vecs[4] = '{len: 1, gap: '{0, 0, 0, 0}, a: '{18'd5, 18'd0, 18'd0, 18'd0},
                b: '{18'd5, 18'd0, 18'd0, 18'd0}, res: 48'd25, rdy: 1};
    vecs[5] = '{len: 2, gap: '{0, 0, 0, 0}, a: '{18'h3FFFD, 18'd2, 18'd0, 18'd0},
                b: '{18'd4, 18'd5, 18'd0, 18'd0}, res: 48'hFFFF_FFFF_FFFE, rdy: 2};
    vecs[6] = '{len: 2, gap: '{0, 0, 0, 0}, a: '{18'h20000, 18'h20000, 18'd0, 18'd0},
                b: '{18'h20000, 18'h20000, 18'd0, 18'd0}, res: 48'h0008_0000_0000, rdy: 2};
    hv = '{len: 2, gap: '{0, 0, 0, 0}, a: '{18'd1, 18'd2, 18'd0, 18'd0},
           b: '{18'd1, 18'd2, 18'd0, 18'd0}, res: 48'd5, rdy: 2};
    rv = '{len: 1, gap: '{0, 0, 0, 0}, a: '{18'd3, 18'd0, 18'd0, 18'd0},
           b: '{18'd3, 18'd0, 18'd0, 18'd0}, res: 48'd9, rdy: 1};

    repeat (2) @(negedge CLK);
    check("reset_ctrl", {39'd0, BUSY, DONE, S_READY, DSP_CEA, DSP_CEB, DSP_CEM,
                         DSP_CEP, DSP_CEOPMODE, DSP_RSTP}, 48'd0);
    check("reset_result", RESULT, 48'd0);
    check("reset_dsp_data", {4'd0, DSP_A, DSP_B, DSP_OPMODE}, 48'd0);
    RSTN = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Abort a LEN=8 run mid-FEED with reset while S_VALID stays high.
    @(negedge CLK);
    START = 1'b1; LEN = 16'd8;
    @(negedge CLK);
    START = 1'b0; S_VALID = 1'b1; S_A = 18'd3; S_B = 18'd3;
    repeat (3) @(negedge CLK);
    check("abort_in_feed", {47'd0, S_READY}, 48'd1);
    d0 = done_cnt;
    RSTN = 1'b0;
    #1;
    check("abort_ctrl", {39'd0, BUSY, DONE, S_READY, DSP_CEA, DSP_CEB, DSP_CEM,
                         DSP_CEP, DSP_CEOPMODE, DSP_RSTP}, 48'd0);
    check("abort_result", RESULT, 48'd0);
    check("abort_dsp_data", {4'd0, DSP_A, DSP_B, DSP_OPMODE}, 48'd0);
    S_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    check("abort_no_done", 48'(done_cnt - d0), 48'd0);
    run_vec(rv, 1'b0, "after_abort");

    // START held high: one command runs, the next is taken only from IDLE after DONE.
    run_vec(hv, 1'b1, "hold");
    LEN = 16'd0;
    @(negedge CLK);
    check("hold_restart_busy", {47'd0, BUSY}, 48'd1);
    START = 1'b0;
    n = 0;
    while (!DONE && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("hold_second_done_seen", {47'd0, DONE}, 48'd1);
    check("hold_second_result", RESULT, 48'd0);
    check("hold_second_latency", 48'(n + 1), 48'd4);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that runs the DSP48A1 slice as a length-N multiply-accumulate engine (dot product / FIR tap loop).
- Accepts a command (START, LEN) and a valid/ready stream of 18-bit operand pairs.
- Drives the slice's A/B/OPMODE/CE/RSTP inputs, tracks pipeline latency, and returns the 48-bit P result.
- Sits between the sample source and the DSP slice instance; the slice is configured with A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1, B_INPUT="DIRECT".

Parameters:
- LEN_W, 16, width of LEN and of the internal sample counter.
- PIPE_LAT, 2, cycles from operands presented on DSP_A/DSP_B to the product being valid at the post-adder (A1/B1 register plus M register).
- OPMODE_MAC, 8'h09, opmode held during accumulation: X=M, Z=P, no pre-adder, add, carry-in 0.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  command strobe; sampled only in IDLE.
- LEN  in  LEN_W  number of operand pairs; latched on the accepted START.
- BUSY  out  1  high from the cycle after an accepted START through the DONE cycle.
- DONE  out  1  one-cycle pulse when RESULT is updated.
- RESULT  out  48  accumulated sum; held until the next DONE.
- S_VALID  in  1  operand pair valid.
- S_READY  out  1  controller accepts a pair this cycle.
- S_A  in  18  multiplicand.
- S_B  in  18  multiplier.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B.
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_CEA  out  1  to slice CEA.
- DSP_CEB  out  1  to slice CEB.
- DSP_CEM  out  1  to slice CEM.
- DSP_CEP  out  1  to slice CEP.
- DSP_CEOPMODE  out  1  to slice CEOPMODE.
- DSP_RSTP  out  1  to slice RSTP (synchronous, active-high at the slice).
- DSP_P  in  48  from slice P.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - state=IDLE; counter=0; valid pipe=0.
  - BUSY=0, DONE=0, RESULT=0, S_READY=0.
  - DSP_A=0, DSP_B=0, DSP_OPMODE=0, all DSP_CE*=0, DSP_RSTP=0.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> FIN -> IDLE.
- IDLE:
  - START=1 latches LEN and moves to CLEAR.
  - START is ignored in every other state.
- CLEAR (exactly 1 cycle):
  - DSP_RSTP=1, DSP_CEP=1, DSP_CEOPMODE=1, DSP_OPMODE=OPMODE_MAC.
  - Next state is FEED if LEN!=0, else DRAIN.
- FEED:
  - S_READY=1 and DSP_CEA=DSP_CEB=DSP_CEM=1.
  - On S_VALID&S_READY: DSP_A=S_A, DSP_B=S_B, counter increments, and a 1 is shifted into the PIPE_LAT-deep valid pipe.
  - Otherwise DSP_A=DSP_B=0 and a 0 is shifted in.
  - The last accepted pair drops S_READY the next cycle and moves to DRAIN.
  - Backpressure bubbles are legal anywhere in the stream.
- DSP_CEP in FEED/DRAIN = valid pipe output, so only real products accumulate into P.
- DSP_OPMODE stays OPMODE_MAC and DSP_CEOPMODE=0 from FEED until return to IDLE.
- DRAIN:
  - CEA/CEB/CEM stay 1 and operands are 0.
  - When the valid pipe is empty, move to FIN.
- FIN (1 cycle): P now holds the final sum. RESULT<=DSP_P, DONE=1 in the following cycle, then IDLE.
- Latency: last accepted pair to DONE = PIPE_LAT+2 cycles.
  - LEN=0: START to DONE = 4 cycles, RESULT=0.
- Arithmetic: signed/unsigned interpretation is the slice's. The controller does no arithmetic on data; wrap at 48 bits is the slice's.
- Reset mid-operation aborts immediately. RESULT returns to 0 and no DONE is issued.
- START asserted in the same cycle as DONE is ignored. It must be reissued in IDLE.

Optional Feature:
- Macro DSP_MAC_OVF_EN.
- When defined:
  - Adds input DSP_CARRYOUT (1b, from slice CARRYOUT) and output OVF (1b).
  - A sticky flag is set on any cycle where the delayed valid pipe output=1 and DSP_CARRYOUT=1. It is cleared in CLEAR.
  - OVF is updated with RESULT at DONE and held with it.
- When undefined: neither port exists and no logic is generated.

Test Plan:
- LEN=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> RESULT=100, one DONE pulse 4 cycles after the last accept, BUSY low the cycle after DONE.
- LEN=3, S_VALID toggling 1,0,0,1,0,1 with pairs (10,10),(2,3),(4,5) -> RESULT=126; DSP_CEP high exactly 3 cycles.
- LEN=0 -> DONE 4 cycles after START, RESULT=0, S_READY never high.
- Two consecutive commands, LEN=2 with (1,1),(1,1) then LEN=1 with (5,5) -> RESULT=2 then 25 (P cleared between commands).
- RSTN pulsed low mid-FEED of a LEN=8 run -> all outputs return to reset values immediately, no DONE; a following LEN=1 (3,3) run gives 9.
- START held high through the whole LEN=2 run -> exactly one command executed; the second START is taken only after returning to IDLE.
